frame_scheduler: RTL
====================

# frame_scheduler

Triple-buffer scheduler for the 32x32 LED matrix pipeline. Owns bank assignment for three frame RAM banks: one filled by the SPI frame reader, one pending, and one scanned out by the panel writer. Frames are swapped only at scan-frame boundaries, after a programmable minimum number of repeats, so the display never tears. Also sequences the panel writer's start pulses and keeps dropped-frame and stale-input status.

## Interface
- REP_BITS, 4, width of `min_repeat` and of the repeat counter
- DROP_W, 8, width of the dropped-frame counter
- STALE_BITS, 24, width of the stale-input timer; timeout is 2^STALE_BITS-1 cycles

- clk  in  1  board clock (40 MHz)
- reset_n  in  1  asynchronous, active-low reset
- wr_done  in  1  1-cycle pulse from the reader: the bank on `wr_bank` now holds a complete frame
- scan_done  in  1  1-cycle pulse from the panel writer: current frame fully scanned out
- min_repeat  in  REP_BITS  minimum completed scans of a frame before it may be replaced; 0 and 1 both mean 1
- wr_bank  out  2  bank the reader writes into
- disp_bank  out  2  bank the panel writer reads from
- disp_valid  out  1  `disp_bank` holds a real frame
- scan_start  out  1  1-cycle pulse: the panel writer begins scanning `disp_bank`
- drop_cnt  out  DROP_W  saturating count of frames overwritten before display
- stale  out  1  no `wr_done` seen for 2^STALE_BITS-1 cycles

## Operation
- Banks are encoded 0, 1 and 2. Code 3 never appears on any output.
- Internal registers:
  - pend_bank (2 bits) and pend_valid.
  - scans: saturating count of completed scans of the current frame, REP_BITS wide.
- Invariant: `wr_bank`, `disp_bank` and `pend_bank` are always pairwise distinct. The free bank is 3 − a − b.
- Reset values:
  - wr_bank=0, pend_bank=1, disp_bank=2.
  - pend_valid=0, disp_valid=0, scans=all-ones.
  - drop_cnt=0, stale=0, scan_start=0, state=IDLE.
- FSM states are IDLE, EVAL, START and SCAN.
  - IDLE: wait for the first frame. Go to EVAL when pend_valid=1.
  - EVAL: decide whether to swap. Always go to START next.
    - Swap condition: pend_valid=1 and scans ≥ max(min_repeat,1).
    - On swap: disp_bank←pend_bank, pend_valid←0, disp_valid←1, scans←0.
  - START: scan_start=1. Go to SCAN.
  - SCAN: on scan_done, scans←scans+1 (saturating) and go to EVAL.
- wr_done is accepted in every state.
  - pend_bank←wr_bank and pend_valid←1.
  - If pend_valid was already 1, the old pending frame is dropped: drop_cnt←drop_cnt+1, saturating at all-ones.
  - New wr_bank = the old pend_bank if it was valid, otherwise the free bank 3 − wr_bank − disp_bank.
- wr_done and an EVAL swap in the same cycle:
  - disp_bank←old pend_bank.
  - pend_bank←old wr_bank, pend_valid←1.
  - wr_bank←old disp_bank.
  - Neither pending frame is dropped, so drop_cnt does not increment.
- scan_done outside SCAN is ignored.
- Stale timer:
  - Clears to 0 on wr_done.
  - Otherwise increments, saturating at all-ones.
  - stale=1 exactly while the timer is saturated.
  - disp_bank is unaffected: the last frame keeps repeating.

## Timing
- All outputs are registered. scan_start is decoded from the state register.
- wr_done at edge t: wr_bank, pend_* and drop_cnt update at t+1.
- First frame after reset:
  - wr_done at edge t.
  - IDLE→EVAL at t+1.
  - START at t+2, with disp_bank and disp_valid already updated; scan_start high for that cycle.
- scan_done at edge t: EVAL at t+1, START (scan_start high) at t+2.
  - Gap from scan_done to the next scan_start is 2 cycles.
- disp_bank changes only on the EVAL→START edge and is stable while scan_start is high.
- Reset asserted mid-scan: all registers go immediately to their reset values, and scan_start drops asynchronously.
- Reset deassertion is synchronized externally. The first active edge after release behaves as a normal IDLE cycle.

## Structure
- Shared package `led_pkg` holds:
  - `bank_t` (logic [1:0]).
  - `sched_state_t` enum {IDLE, EVAL, START, SCAN}.
  - Constant `NBANKS=3`.
  - Function `free_bank(a,b)` returning 3 − a − b.
- One sub-module, `sat_counter #(W)`: clear, increment, saturating output, and a max flag.
  - Instantiated for drop_cnt, the stale timer and scans.
  - scans presets to all-ones on reset.
- Bank-to-RAM address muxing lives in the top-level glue, not in this block.

## Test plan
- Reset, then no stimulus for 10 cycles → wr_bank=0, disp_bank=2, disp_valid=0, scan_start never asserted.
- wr_done at cycle 5 → wr_bank=1 at cycle 6; scan_start at cycle 7 with disp_bank=0 and disp_valid=1.
- min_repeat=3, new frame pending, scan_done pulses 1 and 2 → disp_bank unchanged; on scan_done 3 → disp_bank=pending bank at the next scan_start.
- Three wr_done pulses with no scan_done in between → drop_cnt=2; the last frame is displayed; the three banks stay distinct every cycle.
- wr_done coincident with an EVAL swap → disp_bank=old pending, pend_bank=old wr_bank, wr_bank=old disp_bank, drop_cnt unchanged.
- STALE_BITS=4, no wr_done → stale=1 from cycle 15 onward; the next wr_done clears stale one cycle later. Also assert reset_n low mid-SCAN → all outputs return to reset values with no clock edge.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED matrix frame pipeline.
package led_pkg;

  typedef logic [1:0] bank_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    START = 2'd2,
    SCAN  = 2'd3
  } sched_state_t;

  localparam int NBANKS = 3;

  // With banks 0..2 and a != b, the remaining bank is 3 - a - b.
  function automatic bank_t free_bank(input bank_t a, input bank_t b);
    return bank_t'(2'd3 - a - b);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and an at-maximum flag.
module sat_counter #(
  parameter int W        = 8,
  parameter bit RST_ONES = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         max_o
);

  logic [W-1:0] cnt_q;

  assign max_o = &cnt_q;
  assign cnt_o = cnt_q;

  // Clear wins over increment; increment holds once all-ones is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= {W{RST_ONES}};
    else if (clr_i)            cnt_q <= '0;
    else if (inc_i && !max_o)  cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/frame_scheduler.sv
// Triple-buffer bank scheduler: reader bank, pending bank, displayed bank.
// Swaps happen only between scans, after min_repeat completed scans.
module frame_scheduler
  import led_pkg::*;
#(
  parameter int REP_BITS   = 4,
  parameter int DROP_W     = 8,
  parameter int STALE_BITS = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_done,
  input  logic                scan_done,
  input  logic [REP_BITS-1:0] min_repeat,
  output logic [1:0]          wr_bank,
  output logic [1:0]          disp_bank,
  output logic                disp_valid,
  output logic                scan_start,
  output logic [DROP_W-1:0]   drop_cnt,
  output logic                stale
);

  sched_state_t state_q, state_d;
  bank_t        wr_q, wr_d, pend_q, pend_d, disp_q, disp_d;
  logic         pv_q, pv_d, dv_q, dv_d;

  logic [REP_BITS-1:0] scans, rep_min;
  logic                swap;
  logic                unused_drop_max, unused_scans_max;
  logic [STALE_BITS-1:0] unused_stale_cnt;

  // 0 and 1 both mean "at least one full scan".
  assign rep_min = (min_repeat == '0) ? REP_BITS'(1) : min_repeat;
  assign swap    = (state_q == EVAL) && pv_q && (scans >= rep_min);

  // Completed scans of the current frame; preset to all-ones so the very
  // first frame is eligible immediately.
  sat_counter #(.W(REP_BITS), .RST_ONES(1'b1)) u_scans (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (swap),
    .inc_i ((state_q == SCAN) && scan_done),
    .cnt_o (scans),
    .max_o (unused_scans_max)
  );

  // A frame is dropped only when a valid pending frame is overwritten
  // without being promoted in the same cycle.
  sat_counter #(.W(DROP_W), .RST_ONES(1'b0)) u_drop (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (1'b0),
    .inc_i (wr_done && pv_q && !swap),
    .cnt_o (drop_cnt),
    .max_o (unused_drop_max)
  );

  // Stale timer; the display keeps repeating the last frame regardless.
  sat_counter #(.W(STALE_BITS), .RST_ONES(1'b0)) u_stale (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (wr_done),
    .inc_i (1'b1),
    .cnt_o (unused_stale_cnt),
    .max_o (stale)
  );

  // Bank rotation: promote pending on swap, capture reader bank on wr_done.
  always_comb begin
    wr_d   = wr_q;
    pend_d = pend_q;
    disp_d = disp_q;
    pv_d   = pv_q;
    dv_d   = dv_q;
    if (swap) begin
      disp_d = pend_q;
      dv_d   = 1'b1;
      if (wr_done) begin
        pend_d = wr_q;
        pv_d   = 1'b1;
        wr_d   = disp_q;
      end else begin
        // Park the freed bank in the (now invalid) pending slot so all
        // three codes stay distinct.
        pend_d = disp_q;
        pv_d   = 1'b0;
      end
    end else if (wr_done) begin
      pend_d = wr_q;
      pv_d   = 1'b1;
      wr_d   = pv_q ? pend_q : free_bank(wr_q, disp_q);
    end
  end

  // Scan sequencing; IDLE leaves as soon as a pending frame is being latched.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pv_d) state_d = EVAL;
      EVAL:    state_d = START;
      START:   state_d = SCAN;
      SCAN:    if (scan_done) state_d = EVAL;
      default: state_d = IDLE;
    endcase
  end

  // State and bank registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wr_q    <= 2'd0;
      pend_q  <= 2'd1;
      disp_q  <= 2'd2;
      pv_q    <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      pv_q    <= pv_d;
      dv_q    <= dv_d;
    end
  end

  assign wr_bank    = wr_q;
  assign disp_bank  = disp_q;
  assign disp_valid = dv_q;
  assign scan_start = (state_q == START);

endmodule
